// File: rtl/pzcorebus_csr_slicer.sv
// CSR-profile corebus register slice: per-channel 2-entry skid buffer or pass-through.
// Optional protocol assertions are compiled in when PZCOREBUS_SLICER_SVA_EN is defined.

module pzcorebus_csr_slicer_unit #(
    parameter int WIDTH  = 1,
    parameter int ENABLE = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             accept_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             accept_i,
    output logic [WIDTH-1:0] data_o
);

    if (ENABLE != 0) begin : g_reg
        logic             slot0_vld_q, slot0_vld_d;
        logic             slot1_vld_q, slot1_vld_d;
        logic [WIDTH-1:0] slot0_q, slot0_d;
        logic [WIDTH-1:0] slot1_q, slot1_d;
        logic             push;
        logic             pop;

        // Accept depends only on the skid slot, so the downstream ready never
        // reaches the upstream ready combinationally.
        assign accept_o = !slot1_vld_q;
        assign valid_o  = slot0_vld_q;
        assign data_o   = slot0_q;
        assign push     = valid_i && !slot1_vld_q;
        assign pop      = slot0_vld_q && accept_i;

        always_comb begin
            slot0_vld_d = slot0_vld_q;
            slot1_vld_d = slot1_vld_q;
            slot0_d     = slot0_q;
            slot1_d     = slot1_q;
            if (pop) begin
                if (slot1_vld_q) begin
                    // Push cannot coincide here: accept is low while slot1 is full.
                    slot0_d     = slot1_q;
                    slot1_vld_d = 1'b0;
                end else if (push) begin
                    slot0_d = data_i;
                end else begin
                    slot0_vld_d = 1'b0;
                end
            end else if (push) begin
                if (slot0_vld_q) begin
                    slot1_d     = data_i;
                    slot1_vld_d = 1'b1;
                end else begin
                    slot0_d     = data_i;
                    slot0_vld_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                slot0_vld_q <= 1'b0;
                slot1_vld_q <= 1'b0;
            end else begin
                slot0_vld_q <= slot0_vld_d;
                slot1_vld_q <= slot1_vld_d;
            end
        end

        // Payload is not reset; it only changes when a beat is loaded.
        always_ff @(posedge clk_i) begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end

`ifdef PZCOREBUS_SLICER_SVA_EN
        a_occupancy: assert property (@(posedge clk_i) disable iff (!rst_n_i)
            ((32'(slot0_vld_q) + 32'(slot1_vld_q)) <= 32'd2) && !(slot1_vld_q && !slot0_vld_q));
`endif
    end else begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_n_i;
        assign accept_o = accept_i;
        assign valid_o  = valid_i;
        assign data_o   = data_i;
    end

`ifdef PZCOREBUS_SLICER_SVA_EN
    a_in_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (valid_i && !accept_o) |=> (valid_i && $stable(data_i)));
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (valid_o && !accept_i) |=> (valid_o && $stable(data_o)));
    a_no_x: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !$isunknown(valid_o) && !$isunknown(accept_o));
`endif

endmodule

module pzcorebus_csr_slicer #(
    parameter int ID_WIDTH       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int INFO_WIDTH     = 1,
    parameter int REQUEST_VALID  = 0,
    parameter int RESPONSE_VALID = 0,
    localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  s_mcmd_valid,
    output logic                  s_scmd_accept,
    input  logic [1:0]            s_mcmd,
    input  logic [ID_WIDTH-1:0]   s_mid,
    input  logic [ADDR_WIDTH-1:0] s_maddr,
    input  logic [INFO_WIDTH-1:0] s_minfo,
    input  logic [DATA_WIDTH-1:0] s_mdata,
    input  logic [BE_WIDTH-1:0]   s_mdata_byteen,
    output logic                  m_mcmd_valid,
    input  logic                  m_scmd_accept,
    output logic [1:0]            m_mcmd,
    output logic [ID_WIDTH-1:0]   m_mid,
    output logic [ADDR_WIDTH-1:0] m_maddr,
    output logic [INFO_WIDTH-1:0] m_minfo,
    output logic [DATA_WIDTH-1:0] m_mdata,
    output logic [BE_WIDTH-1:0]   m_mdata_byteen,
    input  logic                  m_sresp_valid,
    output logic                  m_mresp_accept,
    input  logic                  m_sresp,
    input  logic [ID_WIDTH-1:0]   m_sid,
    input  logic                  m_serror,
    input  logic [INFO_WIDTH-1:0] m_sinfo,
    input  logic [DATA_WIDTH-1:0] m_sdata,
    output logic                  s_sresp_valid,
    input  logic                  s_mresp_accept,
    output logic                  s_sresp,
    output logic [ID_WIDTH-1:0]   s_sid,
    output logic                  s_serror,
    output logic [INFO_WIDTH-1:0] s_sinfo,
    output logic [DATA_WIDTH-1:0] s_sdata
);

    localparam int CMD_W  = 2 + ID_WIDTH + ADDR_WIDTH + INFO_WIDTH + DATA_WIDTH + BE_WIDTH;
    localparam int RESP_W = 1 + ID_WIDTH + 1 + INFO_WIDTH + DATA_WIDTH;

    logic [CMD_W-1:0]  cmd_in, cmd_out;
    logic [RESP_W-1:0] resp_in, resp_out;

    assign cmd_in = {s_mcmd, s_mid, s_maddr, s_minfo, s_mdata, s_mdata_byteen};
    assign {m_mcmd, m_mid, m_maddr, m_minfo, m_mdata, m_mdata_byteen} = cmd_out;

    assign resp_in = {m_sresp, m_sid, m_serror, m_sinfo, m_sdata};
    assign {s_sresp, s_sid, s_serror, s_sinfo, s_sdata} = resp_out;

    pzcorebus_csr_slicer_unit #(
        .WIDTH  (CMD_W),
        .ENABLE (REQUEST_VALID)
    ) u_cmd (
        .clk_i    (i_clk),
        .rst_n_i  (i_rst_n),
        .valid_i  (s_mcmd_valid),
        .accept_o (s_scmd_accept),
        .data_i   (cmd_in),
        .valid_o  (m_mcmd_valid),
        .accept_i (m_scmd_accept),
        .data_o   (cmd_out)
    );

    pzcorebus_csr_slicer_unit #(
        .WIDTH  (RESP_W),
        .ENABLE (RESPONSE_VALID)
    ) u_resp (
        .clk_i    (i_clk),
        .rst_n_i  (i_rst_n),
        .valid_i  (m_sresp_valid),
        .accept_o (m_mresp_accept),
        .data_i   (resp_in),
        .valid_o  (s_sresp_valid),
        .accept_i (s_mresp_accept),
        .data_o   (resp_out)
    );

endmodule

// File: tb/tb_pzcorebus_csr_slicer.sv
// Bench for pzcorebus_csr_slicer: registered and pass-through instances share stimulus;
// a queue-based occupancy model scores the registered one, identity scores pass-through.

module tb_pzcorebus_csr_slicer;

    localparam int IW = 4, AW = 32, DW = 32, NW = 1, BW = DW / 8;
    localparam int CW = 2 + IW + AW + NW + DW + BW;
    localparam int RW = 1 + IW + 1 + NW + DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Stimulus
    logic          cmd_v = 1'b0, m_acc = 1'b0, rsp_v = 1'b0, s_acc = 1'b0;
    logic [CW-1:0] cmd_in = '0;
    logic [RW-1:0] rsp_in = '0;

    // Registered instance outputs
    logic r_s_acc, r_m_v, r_m_racc, r_s_rv, r_sresp, r_serror;
    logic [1:0] r_mcmd; logic [IW-1:0] r_mid, r_sid; logic [AW-1:0] r_maddr;
    logic [NW-1:0] r_minfo, r_sinfo; logic [DW-1:0] r_mdata, r_sdata; logic [BW-1:0] r_be;
    // Pass-through instance outputs
    logic p_s_acc, p_m_v, p_m_racc, p_s_rv, p_sresp, p_serror;
    logic [1:0] p_mcmd; logic [IW-1:0] p_mid, p_sid; logic [AW-1:0] p_maddr;
    logic [NW-1:0] p_minfo, p_sinfo; logic [DW-1:0] p_mdata, p_sdata; logic [BW-1:0] p_be;

    logic [CW-1:0] r_cmd_out, p_cmd_out;
    logic [RW-1:0] r_rsp_out, p_rsp_out;
    assign r_cmd_out = {r_mcmd, r_mid, r_maddr, r_minfo, r_mdata, r_be};
    assign p_cmd_out = {p_mcmd, p_mid, p_maddr, p_minfo, p_mdata, p_be};
    assign r_rsp_out = {r_sresp, r_sid, r_serror, r_sinfo, r_sdata};
    assign p_rsp_out = {p_sresp, p_sid, p_serror, p_sinfo, p_sdata};

    pzcorebus_csr_slicer #(
        .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INFO_WIDTH(NW),
        .REQUEST_VALID(1), .RESPONSE_VALID(1)
    ) dut_r (
        .i_clk(clk), .i_rst_n(rst_n),
        .s_mcmd_valid(cmd_v), .s_scmd_accept(r_s_acc),
        .s_mcmd(cmd_in[CW-1 -: 2]), .s_mid(cmd_in[NW+DW+BW+AW +: IW]),
        .s_maddr(cmd_in[NW+DW+BW +: AW]), .s_minfo(cmd_in[DW+BW +: NW]),
        .s_mdata(cmd_in[BW +: DW]), .s_mdata_byteen(cmd_in[BW-1:0]),
        .m_mcmd_valid(r_m_v), .m_scmd_accept(m_acc),
        .m_mcmd(r_mcmd), .m_mid(r_mid), .m_maddr(r_maddr), .m_minfo(r_minfo),
        .m_mdata(r_mdata), .m_mdata_byteen(r_be),
        .m_sresp_valid(rsp_v), .m_mresp_accept(r_m_racc),
        .m_sresp(rsp_in[RW-1]), .m_sid(rsp_in[DW+NW+1 +: IW]), .m_serror(rsp_in[DW+NW]),
        .m_sinfo(rsp_in[DW +: NW]), .m_sdata(rsp_in[DW-1:0]),
        .s_sresp_valid(r_s_rv), .s_mresp_accept(s_acc),
        .s_sresp(r_sresp), .s_sid(r_sid), .s_serror(r_serror), .s_sinfo(r_sinfo), .s_sdata(r_sdata)
    );

    pzcorebus_csr_slicer #(
        .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INFO_WIDTH(NW),
        .REQUEST_VALID(0), .RESPONSE_VALID(0)
    ) dut_p (
        .i_clk(clk), .i_rst_n(rst_n),
        .s_mcmd_valid(cmd_v), .s_scmd_accept(p_s_acc),
        .s_mcmd(cmd_in[CW-1 -: 2]), .s_mid(cmd_in[NW+DW+BW+AW +: IW]),
        .s_maddr(cmd_in[NW+DW+BW +: AW]), .s_minfo(cmd_in[DW+BW +: NW]),
        .s_mdata(cmd_in[BW +: DW]), .s_mdata_byteen(cmd_in[BW-1:0]),
        .m_mcmd_valid(p_m_v), .m_scmd_accept(m_acc),
        .m_mcmd(p_mcmd), .m_mid(p_mid), .m_maddr(p_maddr), .m_minfo(p_minfo),
        .m_mdata(p_mdata), .m_mdata_byteen(p_be),
        .m_sresp_valid(rsp_v), .m_mresp_accept(p_m_racc),
        .m_sresp(rsp_in[RW-1]), .m_sid(rsp_in[DW+NW+1 +: IW]), .m_serror(rsp_in[DW+NW]),
        .m_sinfo(rsp_in[DW +: NW]), .m_sdata(rsp_in[DW-1:0]),
        .s_sresp_valid(p_s_rv), .s_mresp_accept(s_acc),
        .s_sresp(p_sresp), .s_sid(p_sid), .s_serror(p_serror), .s_sinfo(p_sinfo), .s_sdata(p_sdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // Model: a channel is an in-order queue of accepted-but-undelivered beats.
    // Output valid iff the queue is non-empty; upstream accept iff fewer than 2 are held.
    logic [CW-1:0] cmd_q[$], cmd_src[$];
    logic [RW-1:0] rsp_q[$], rsp_src[$];
    logic cmd_fire = 1'b0, rsp_fire = 1'b0;

    always @(negedge clk) begin
        // Pass-through: outputs equal inputs in the same cycle, reset or not.
        chk("pt_cmd_valid", p_m_v, cmd_v);
        chk("pt_cmd_payload", p_cmd_out, cmd_in);
        chk("pt_cmd_accept", p_s_acc, m_acc);
        chk("pt_rsp_valid", p_s_rv, rsp_v);
        chk("pt_rsp_payload", p_rsp_out, rsp_in);
        chk("pt_rsp_accept", p_m_racc, s_acc);
        if (!rst_n) begin
            cmd_q.delete();
            rsp_q.delete();
            cmd_fire = 1'b0;
            rsp_fire = 1'b0;
        end else begin
            chk("cmd_valid", r_m_v, cmd_q.size() > 0);
            chk("cmd_accept", r_s_acc, cmd_q.size() < 2);
            if (r_m_v && cmd_q.size() > 0) begin
                chk("cmd_payload", r_cmd_out, cmd_q[0]);
                if (m_acc) void'(cmd_q.pop_front());
            end
            cmd_fire = cmd_v && r_s_acc;
            if (cmd_fire) cmd_q.push_back(cmd_in);

            chk("rsp_valid", r_s_rv, rsp_q.size() > 0);
            chk("rsp_accept", r_m_racc, rsp_q.size() < 2);
            if (r_s_rv && rsp_q.size() > 0) begin
                chk("rsp_payload", r_rsp_out, rsp_q[0]);
                if (s_acc) void'(rsp_q.pop_front());
            end
            rsp_fire = rsp_v && r_m_racc;
            if (rsp_fire) rsp_q.push_back(rsp_in);
        end
    end

    int unsigned cmd_pct = 0, macc_pct = 0, rsp_pct = 0, sacc_pct = 0;

    function automatic logic [CW-1:0] rand_cmd();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[CW-1:0];
    endfunction

    function automatic logic [RW-1:0] rand_rsp();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[RW-1:0];
    endfunction

    function automatic logic [CW-1:0] mk_cmd(input logic [AW-1:0] addr);
        logic [CW-1:0] c;
        c = rand_cmd();
        c[NW+DW+BW +: AW] = addr;
        return c;
    endfunction

    function automatic logic [RW-1:0] mk_rsp(input logic [IW-1:0] sid, input logic [DW-1:0] d);
        logic [RW-1:0] r;
        r = rand_rsp();
        r[DW+NW+1 +: IW] = sid;
        r[DW-1:0] = d;
        return r;
    endfunction

    // Advance one cycle and drive the next one; a presented beat is held until it fires.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (!(cmd_v && !cmd_fire)) begin
            if (cmd_src.size() > 0 && $urandom_range(99) < cmd_pct) begin
                cmd_in = cmd_src.pop_front();
                cmd_v  = 1'b1;
            end else begin
                cmd_v = 1'b0;
            end
        end
        if (!(rsp_v && !rsp_fire)) begin
            if (rsp_src.size() > 0 && $urandom_range(99) < rsp_pct) begin
                rsp_in = rsp_src.pop_front();
                rsp_v  = 1'b1;
            end else begin
                rsp_v = 1'b0;
            end
        end
        m_acc = $urandom_range(99) < macc_pct;
        s_acc = $urandom_range(99) < sacc_pct;
    endtask

    initial begin
        repeat (3) cycle();
        rst_n = 1'b1;

        // Back-to-back commands at full accept: 1-cycle latency, no bubbles.
        macc_pct = 100; cmd_pct = 100;
        for (int i = 0; i < 8; i++) cmd_src.push_back(mk_cmd(32'(i * 4)));
        repeat (12) cycle();

        // Backpressure: two beats stored, third held upstream, then drained.
        macc_pct = 0;
        for (int i = 0; i < 3; i++) cmd_src.push_back(mk_cmd(32'h100 + 32'(i * 4)));
        repeat (6) cycle();
        macc_pct = 100;
        repeat (6) cycle();

        // Responses under a toggling downstream accept.
        rsp_pct = 100;
        for (int i = 0; i < 4; i++) rsp_src.push_back(mk_rsp(IW'(i + 1), 32'hA0 + 32'(i)));
        for (int i = 0; i < 12; i++) begin
            sacc_pct = (i % 2 == 0) ? 100 : 0;
            cycle();
        end
        sacc_pct = 100;
        repeat (3) cycle();

        // Reset with two beats buffered.
        macc_pct = 0;
        for (int i = 0; i < 2; i++) cmd_src.push_back(mk_cmd(32'h200 + 32'(i * 4)));
        repeat (4) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        macc_pct = 100;
        cmd_src.push_back(mk_cmd(32'h300));
        repeat (4) cycle();

        // Steady push/pop at occupancy 1.
        for (int i = 0; i < 10; i++) cmd_src.push_back(mk_cmd(32'h400 + 32'(i * 4)));
        repeat (13) cycle();

        // Random traffic on both channels.
        for (int blk = 0; blk < 20; blk++) begin
            cmd_pct  = $urandom_range(100);
            macc_pct = $urandom_range(100);
            rsp_pct  = $urandom_range(100);
            sacc_pct = $urandom_range(100);
            for (int c = 0; c < 100; c++) begin
                if (cmd_src.size() < 4) cmd_src.push_back(rand_cmd());
                if (rsp_src.size() < 4) rsp_src.push_back(rand_rsp());
                cycle();
            end
        end

        // Drain: all accepted beats must come out.
        cmd_src.delete();
        rsp_src.delete();
        macc_pct = 100; sacc_pct = 100;
        repeat (10) cycle();
        chk("cmd_drain", 128'(cmd_q.size()), 128'd0);
        chk("rsp_drain", 128'(rsp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pzcorebus_csr_slicer.md
Name: pzcorebus_csr_slicer

Overview:
- Register slice for a CSR-profile corebus link: one command channel (master→slave) and one response channel (slave→master).
- Each channel is independently either a full-throughput 2-entry skid buffer or a combinational pass-through.
- Inserted at the slave and master boundaries of CSR-bus width converters and fabric blocks to break timing paths.
- Payload is opaque; never modified or reordered.

Parameters:
- ID_WIDTH, 4, width of mid/sid.
- ADDR_WIDTH, 32, width of maddr.
- DATA_WIDTH, 32, width of mdata/sdata; multiple of 8; byte-enable width BE_WIDTH = DATA_WIDTH/8.
- INFO_WIDTH, 1, width of minfo/sinfo; minimum 1.
- REQUEST_VALID, 0, 1 = command channel registered, 0 = pass-through.
- RESPONSE_VALID, 0, 1 = response channel registered, 0 = pass-through.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- s_mcmd_valid  in  1  upstream command valid
- s_scmd_accept  out  1  upstream command ready
- s_mcmd  in  2  command code
- s_mid  in  ID_WIDTH  request ID
- s_maddr  in  ADDR_WIDTH  address
- s_minfo  in  INFO_WIDTH  sideband
- s_mdata  in  DATA_WIDTH  write data
- s_mdata_byteen  in  BE_WIDTH  byte enables
- m_mcmd_valid, m_mcmd, m_mid, m_maddr, m_minfo, m_mdata, m_mdata_byteen  out  (same widths)  downstream command
- m_scmd_accept  in  1  downstream command ready
- m_sresp_valid  in  1  downstream response valid
- m_mresp_accept  out  1  downstream response ready
- m_sresp  in  1  response code
- m_sid  in  ID_WIDTH  response ID
- m_serror  in  1  error flag
- m_sinfo  in  INFO_WIDTH  sideband
- m_sdata  in  DATA_WIDTH  read data
- s_sresp_valid, s_sresp, s_sid, s_serror, s_sinfo, s_sdata  out  (same widths)  upstream response
- s_mresp_accept  in  1  upstream response ready

Behaviour:
- Clocking and reset: single clock i_clk. Reset i_rst_n is synchronous and active-low.
- Handshake: transfer occurs when valid && accept on the same rising edge. A sender never drops valid or changes payload until accepted; the slice preserves this on its outputs.
- Command path, pass-through (REQUEST_VALID=0):
  - All m_* command outputs equal the s_* inputs.
  - s_scmd_accept = m_scmd_accept.
  - No state.
- Response path, pass-through (RESPONSE_VALID=0): same rule in the reverse direction.
- Registered channel (skid buffer), per channel:
  - Storage: two entries, slot0 (output) and slot1 (skid), each with a valid bit.
  - Output: valid = slot0.valid; payload = slot0 payload.
  - Upstream accept = !slot1.valid. It is a registered signal, with no combinational path from downstream accept.
  - Push when upstream valid && accept. Pop when output valid && downstream accept.
  - Push into empty or popping slot0 → slot0. Push while slot0 held → slot1.
  - On pop with slot1 valid, slot1 moves to slot0.
  - Latency: 1 cycle input→output.
  - Throughput: 1 beat/cycle sustained, with zero bubbles under continuous accept.
  - Order strictly preserved.
  - Full (both slots valid): upstream accept=0. Next pop frees slot1, and accept returns to 1 in the following cycle.
  - Simultaneous push and pop with one entry: the new beat lands in slot0; occupancy stays 1.
- Reset values:
  - All valid bits 0, so m_mcmd_valid=0 and s_sresp_valid=0 in registered mode.
  - Upstream accepts = 1 during and after reset.
  - Payload registers are not reset; they are don't-care while invalid.
  - Reset asserted mid-operation discards all buffered beats at that edge.
- Pass-through outputs during reset follow their inputs.
- Payload registers load only on push; no toggling while idle.

Optional Feature:
- Macro PZCOREBUS_SLICER_SVA_EN.
- Defined: compile protocol assertions on both sides of each channel (disabled while i_rst_n=0):
  - valid && !accept ⇒ valid and payload stable next cycle.
  - No X on valid outputs after reset.
  - Buffer occupancy never exceeds 2.
- Undefined: no assertions; RTL otherwise identical.

Test Plan:
- Registered command, m_scmd_accept=1, push 8 consecutive beats maddr=0x00,0x04..0x1C → m_mcmd_valid rises 1 cycle after the first push, then 8 beats on 8 consecutive cycles, same order, s_scmd_accept constantly 1.
- Backpressure: m_scmd_accept=0, push 3 beats → beats 1–2 stored, s_scmd_accept=0 from the cycle after the 2nd push, beat 3 held upstream. Raise accept → all 3 delivered in order with no loss or duplicate.
- Pass-through both channels → outputs equal inputs in the same cycle; s_scmd_accept follows m_scmd_accept combinationally.
- Registered response, s_mresp_accept toggling 1,0,1,0, responses sid=1..4, sdata=0xA0..0xA3 → delivered in order, payload stable while stalled.
- Reset asserted while 2 beats buffered → next cycle m_mcmd_valid=0, s_scmd_accept=1; after release the first new beat appears with 1-cycle latency.
- Simultaneous push/pop at occupancy 1, 10 cycles → occupancy stays 1 and output updates every cycle.
